// File: rtl/snn_pkg.sv
// snn_pkg: shared AER constants, default event type (ts field only with AER_TIMESTAMP_EN)
package snn_pkg;
    localparam int DROP_CNT_W = 8;
    localparam int DROP_MAX = 2 ** DROP_CNT_W - 1;
    localparam int AER_N = 4;
    localparam int AER_AW = $clog2(AER_N);
    localparam int AER_TS_W = 16;
    typedef struct packed {
        logic [AER_AW-1:0] addr;
`ifdef AER_TIMESTAMP_EN
        logic [AER_TS_W-1:0] ts;
`endif
    } aer_event_t;
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction
endpackage

// File: rtl/aer_fifo.sv
// aer_fifo: show-ahead event FIFO; head is visible while valid, zero when empty
module aer_fifo #(
    parameter int W = 2,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          valid,
    output logic          full,
    output logic [LW-1:0] level
);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    // storage array needs no reset; empty entries are masked at the output
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
    // pointers and occupancy; push and pop in one cycle leave the level unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
        end
    end
    assign valid = level != '0;
    assign full  = level == LW'(DEPTH);
    assign dout  = valid ? mem[rd_ptr] : '0;
endmodule

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: round-robin serialiser of spike pulses into AER events; AER_TIMESTAMP_EN adds ev_ts
module spike_aer_encoder
    import snn_pkg::*;
#(
    parameter int N = AER_N,
    parameter int DEPTH = 4,
`ifdef AER_TIMESTAMP_EN
    parameter int TS_W = AER_TS_W,
`endif
    localparam int AW = clog2_min1(N),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          spike_in,
    output logic                  ev_valid,
    input  logic                  ev_ready,
    output logic [AW-1:0]         ev_addr,
`ifdef AER_TIMESTAMP_EN
    output logic [TS_W-1:0]       ev_ts,
`endif
    output logic [LW-1:0]         fifo_level,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  overflow
);
    logic [N-1:0] pending, grant, dropped;
    logic [AW-1:0] rr_ptr, gnt_idx;
    logic gnt_any, pop, full, can_accept;
    int drop_sum;
    assign pop        = ev_valid && ev_ready;
    assign can_accept = !full || pop;
    // round-robin search starting just after the last granted neuron
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = rr_ptr;
        for (int k = 1; k <= N; k++) begin
            if (!gnt_any && can_accept && pending[(int'(rr_ptr) + k) % N]) begin
                gnt_any = 1'b1;
                gnt_idx = AW'((int'(rr_ptr) + k) % N);
            end
        end
        grant = gnt_any ? N'(1) << gnt_idx : '0;
    end
    // a spike on a still-pending, ungranted neuron is lost and must be counted
    always_comb begin
        dropped  = spike_in & pending & ~grant;
        drop_sum = int'(drop_cnt) + $countones(dropped);
    end
    // pending spikes, arbiter pointer and loss bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            rr_ptr   <= AW'(N - 1);
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= (pending & ~grant) | spike_in;
            if (gnt_any) rr_ptr <= gnt_idx;
            drop_cnt <= (drop_sum > DROP_MAX) ? DROP_CNT_W'(DROP_MAX) : DROP_CNT_W'(drop_sum);
            overflow <= overflow | (|dropped);
        end
    end
`ifdef AER_TIMESTAMP_EN
    localparam int EW = AW + TS_W;
    logic [TS_W-1:0] ts_cnt;
    logic [EW-1:0] din, head;
    // free-running timestamp, sampled into the event on the grant cycle
    always_ff @(posedge clk) begin
        ts_cnt <= reset ? '0 : ts_cnt + 1'b1;
    end
    assign din = {gnt_idx, ts_cnt};
    assign {ev_addr, ev_ts} = head;
`else
    localparam int EW = AW;
    logic [EW-1:0] din, head;
    assign din = gnt_idx;
    assign ev_addr = head;
`endif
    aer_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (gnt_any),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .valid (ev_valid),
        .full  (full),
        .level (fifo_level)
    );
endmodule
